// File: rtl/sprite_pkg.sv
// Shared colour type and constants for the sprite layer mapper.
package sprite_pkg;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   localparam logic [7:0] BG_BLUE_BASE = 8'h7F;
   localparam rgb_t       WHITE        = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};
   localparam int         HIT_ID_W     = 3;

endpackage

// File: rtl/sprite_channel.sv
// One sprite channel: frame-latched shadow registers, flash counter
// and the registered stage-1 hit for the current pixel.
module sprite_channel
   import sprite_pkg::*;
#(
   parameter int COORD_W      = 10,
   parameter int FLASH_FRAMES = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               frame_start,
   input  logic               pix_valid,
   input  logic [COORD_W-1:0] draw_x,
   input  logic [COORD_W-1:0] draw_y,
   input  logic [COORD_W-1:0] x_in,
   input  logic [COORD_W-1:0] y_in,
   input  logic [COORD_W-1:0] size_in,
   input  rgb_t               rgb_in,
   input  logic               en_in,
   input  logic               slice,
   output logic               hit,
   output rgb_t               rgb,
   output logic               flash
);

   logic [COORD_W-1:0] x_q, x_d;
   logic [COORD_W-1:0] y_q, y_d;
   logic [COORD_W-1:0] size_q, size_d;
   rgb_t               rgb_q, rgb_d;
   logic               en_q, en_d;
   logic [7:0]         cnt_q, cnt_d;
   logic               hit_q, hit_d;
   logic [COORD_W-1:0] dx, dy;

   always_comb begin
      x_d    = x_q;
      y_d    = y_q;
      size_d = size_q;
      rgb_d  = rgb_q;
      en_d   = en_q;
      if (frame_start) begin
         x_d    = x_in;
         y_d    = y_in;
         size_d = size_in;
         rgb_d  = rgb_in;
         en_d   = en_in;
      end
      // A slice wins over the frame decrement so retriggers never lose a frame.
      cnt_d = cnt_q;
      if (slice) begin
         cnt_d = 8'(FLASH_FRAMES);
      end else if (frame_start && cnt_q != 8'd0) begin
         cnt_d = cnt_q - 8'd1;
      end
      // Modular offsets make coordinates left/above the sprite wrap large.
      dx    = draw_x - x_q;
      dy    = draw_y - y_q;
      hit_d = pix_valid && en_q && (dx < size_q) && (dy < size_q);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         x_q    <= '0;
         y_q    <= '0;
         size_q <= '0;
         rgb_q  <= '0;
         en_q   <= 1'b0;
         cnt_q  <= '0;
         hit_q  <= 1'b0;
      end else begin
         x_q    <= x_d;
         y_q    <= y_d;
         size_q <= size_d;
         rgb_q  <= rgb_d;
         en_q   <= en_d;
         cnt_q  <= cnt_d;
         hit_q  <= hit_d;
      end
   end

   assign hit   = hit_q;
   assign rgb   = rgb_q;
   assign flash = (cnt_q != 8'd0);

endmodule

// File: rtl/sprite_layer_mapper.sv
// Sprite compositor: per-channel hit tests, lowest-index priority,
// flash-to-white and a gradient background, two cycles of latency.
module sprite_layer_mapper
   import sprite_pkg::*;
#(
   parameter int NUM_SPRITES  = 4,
   parameter int COORD_W      = 10,
   parameter int FLASH_FRAMES = 8
) (
   input  logic                           Clk,
   input  logic                           Reset,
   input  logic                           frame_start,
   input  logic                           pix_valid,
   input  logic [COORD_W-1:0]             DrawX,
   input  logic [COORD_W-1:0]             DrawY,
   input  logic [NUM_SPRITES*COORD_W-1:0] spr_x,
   input  logic [NUM_SPRITES*COORD_W-1:0] spr_y,
   input  logic [NUM_SPRITES*COORD_W-1:0] spr_size,
   input  logic [NUM_SPRITES*24-1:0]      spr_rgb,
   input  logic [NUM_SPRITES-1:0]         spr_en,
   input  logic [NUM_SPRITES-1:0]         spr_slice,
   output logic [7:0]                     Red,
   output logic [7:0]                     Green,
   output logic [7:0]                     Blue,
   output logic                           rgb_valid,
   output logic                           hit_any,
   output logic [HIT_ID_W-1:0]            hit_id
);

   logic [NUM_SPRITES-1:0] hit1;
   logic [NUM_SPRITES-1:0] flash;
   rgb_t                   ch_rgb [NUM_SPRITES];

   for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_ch
      sprite_channel #(
         .COORD_W      (COORD_W),
         .FLASH_FRAMES (FLASH_FRAMES)
      ) u_ch (
         .clk         (Clk),
         .reset       (Reset),
         .frame_start (frame_start),
         .pix_valid   (pix_valid),
         .draw_x      (DrawX),
         .draw_y      (DrawY),
         .x_in        (spr_x[i*COORD_W +: COORD_W]),
         .y_in        (spr_y[i*COORD_W +: COORD_W]),
         .size_in     (spr_size[i*COORD_W +: COORD_W]),
         .rgb_in      (spr_rgb[i*24 +: 24]),
         .en_in       (spr_en[i]),
         .slice       (spr_slice[i]),
         .hit         (hit1[i]),
         .rgb         (ch_rgb[i]),
         .flash       (flash[i])
      );
   end

   logic [6:0]          xcol_q, xcol_d;
   logic                valid1_q, valid1_d;
   logic                valid2_q, valid2_d;
   logic                any2_q, any2_d;
   logic [HIT_ID_W-1:0] id2_q, id2_d;
   rgb_t                rgb2_q, rgb2_d;
   logic                win_any;
   logic [HIT_ID_W-1:0] win_id;
   rgb_t                win_rgb;

   always_comb begin
      valid1_d = pix_valid;
      xcol_d   = pix_valid ? DrawX[COORD_W-1 -: 7] : 7'd0;
      win_any  = 1'b0;
      win_id   = '0;
      win_rgb  = '0;
      // Scan downwards so the lowest-index hit is the last to be kept.
      for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
         if (hit1[i]) begin
            win_any = 1'b1;
            win_id  = HIT_ID_W'(i);
            win_rgb = flash[i] ? WHITE : ch_rgb[i];
         end
      end
      valid2_d = valid1_q;
      any2_d   = valid1_q && win_any;
      id2_d    = any2_d ? win_id : '0;
      rgb2_d   = '0;
      if (valid1_q) begin
         if (win_any) begin
            rgb2_d = win_rgb;
         end else begin
            rgb2_d.b = BG_BLUE_BASE - {1'b0, xcol_q};
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         xcol_q   <= '0;
         valid1_q <= 1'b0;
         valid2_q <= 1'b0;
         any2_q   <= 1'b0;
         id2_q    <= '0;
         rgb2_q   <= '0;
      end else begin
         xcol_q   <= xcol_d;
         valid1_q <= valid1_d;
         valid2_q <= valid2_d;
         any2_q   <= any2_d;
         id2_q    <= id2_d;
         rgb2_q   <= rgb2_d;
      end
   end

   assign Red       = rgb2_q.r;
   assign Green     = rgb2_q.g;
   assign Blue      = rgb2_q.b;
   assign rgb_valid = valid2_q;
   assign hit_any   = any2_q;
   assign hit_id    = id2_q;

endmodule

// File: tb/tb_sprite_layer_mapper.sv
// Self-checking bench for sprite_layer_mapper: vector table, directed
// corner sequences and random pixel streams against a behavioural model.
module tb_sprite_layer_mapper;

   localparam int NS = 4;
   localparam int CW = 10;
   localparam int FF = 8;

   localparam logic [23:0] CA = 24'hC01020;
   localparam logic [23:0] CB = 24'h30A050;
   localparam logic [23:0] CC = 24'h2040F0;
   localparam logic [23:0] CD = 24'h00FF00;
   localparam logic [23:0] WH = 24'hFFFFFF;

   logic             Clk = 1'b0;
   logic             Reset = 1'b0;
   logic             frame_start = 1'b0;
   logic             pix_valid = 1'b0;
   logic [CW-1:0]    DrawX = '0;
   logic [CW-1:0]    DrawY = '0;
   logic [NS*CW-1:0] spr_x = '0;
   logic [NS*CW-1:0] spr_y = '0;
   logic [NS*CW-1:0] spr_size = '0;
   logic [NS*24-1:0] spr_rgb = '0;
   logic [NS-1:0]    spr_en = '0;
   logic [NS-1:0]    spr_slice = '0;
   logic [7:0]       Red, Green, Blue;
   logic             rgb_valid, hit_any;
   logic [2:0]       hit_id;

   int n_assert = 0;
   int n_fail   = 0;

   int          in_x [NS], in_y [NS], in_sz [NS];
   logic [23:0] in_rgb [NS];
   bit          in_en [NS];
   int          m_x [NS], m_y [NS], m_sz [NS], m_cnt [NS];
   logic [23:0] m_rgb [NS];
   bit          m_en [NS];

   typedef struct {
      int          x;
      int          y;
      logic [23:0] rgb;
      logic        any;
      int          id;
   } vec_t;

   vec_t tbl [8];

   sprite_layer_mapper #(
      .NUM_SPRITES  (NS),
      .COORD_W      (CW),
      .FLASH_FRAMES (FF)
   ) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .frame_start (frame_start),
      .pix_valid   (pix_valid),
      .DrawX       (DrawX),
      .DrawY       (DrawY),
      .spr_x       (spr_x),
      .spr_y       (spr_y),
      .spr_size    (spr_size),
      .spr_rgb     (spr_rgb),
      .spr_en      (spr_en),
      .spr_slice   (spr_slice),
      .Red         (Red),
      .Green       (Green),
      .Blue        (Blue),
      .rgb_valid   (rgb_valid),
      .hit_any     (hit_any),
      .hit_id      (hit_id)
   );

   always #5 Clk = ~Clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic out_chk(input string nm, input logic v,
                          input logic [23:0] rgb, input logic a,
                          input int id);
      chk({nm, ".valid"}, 32'(rgb_valid), 32'(v));
      chk({nm, ".rgb"}, 32'({Red, Green, Blue}), 32'(rgb));
      chk({nm, ".hit_any"}, 32'(hit_any), 32'(a));
      chk({nm, ".hit_id"}, 32'(hit_id), 32'(id));
   endtask

   // Reference: modular offset test, first enabled hit wins,
   // background blue falls by one every 8 columns.
   function automatic void model_pix(input int px, input int py,
                                     output logic [23:0] rgb,
                                     output logic a, output int id);
      int dx, dy;
      a   = 1'b0;
      id  = 0;
      rgb = {16'h0, 8'(127 - px / 8)};
      for (int i = 0; i < NS; i++) begin
         dx = ((px - m_x[i]) % 1024 + 1024) % 1024;
         dy = ((py - m_y[i]) % 1024 + 1024) % 1024;
         if (!a && m_en[i] && dx < m_sz[i] && dy < m_sz[i]) begin
            a   = 1'b1;
            id  = i;
            rgb = (m_cnt[i] > 0) ? WH : m_rgb[i];
         end
      end
   endfunction

   task automatic set_spr(input int i, input int x, input int y,
                          input int sz, input logic [23:0] c,
                          input bit en);
      in_x[i]   = x;
      in_y[i]   = y;
      in_sz[i]  = sz;
      in_rgb[i] = c;
      in_en[i]  = en;
      spr_x[i*CW +: CW]    = CW'(x);
      spr_y[i*CW +: CW]    = CW'(y);
      spr_size[i*CW +: CW] = CW'(sz);
      spr_rgb[i*24 +: 24]  = c;
      spr_en[i]            = en;
   endtask

   task automatic clear_model();
      for (int i = 0; i < NS; i++) begin
         m_x[i]   = 0;
         m_y[i]   = 0;
         m_sz[i]  = 0;
         m_rgb[i] = '0;
         m_en[i]  = 1'b0;
         m_cnt[i] = 0;
      end
   endtask

   task automatic frame(input logic [NS-1:0] sl);
      frame_start = 1'b1;
      spr_slice   = sl;
      @(posedge Clk); #1;
      frame_start = 1'b0;
      spr_slice   = '0;
      for (int i = 0; i < NS; i++) begin
         m_x[i]   = in_x[i];
         m_y[i]   = in_y[i];
         m_sz[i]  = in_sz[i];
         m_rgb[i] = in_rgb[i];
         m_en[i]  = in_en[i];
         if (sl[i]) m_cnt[i] = FF;
         else if (m_cnt[i] > 0) m_cnt[i]--;
      end
   endtask

   task automatic slice(input logic [NS-1:0] sl);
      spr_slice = sl;
      @(posedge Clk); #1;
      spr_slice = '0;
      for (int i = 0; i < NS; i++)
         if (sl[i]) m_cnt[i] = FF;
   endtask

   // Everything that normally has an effect is asserted alongside Reset.
   task automatic do_reset();
      Reset       = 1'b1;
      frame_start = 1'b1;
      spr_slice   = '1;
      pix_valid   = 1'b1;
      DrawX       = CW'(206);
      DrawY       = CW'(205);
      @(posedge Clk); #1;
      Reset       = 1'b0;
      frame_start = 1'b0;
      spr_slice   = '0;
      pix_valid   = 1'b0;
      clear_model();
      out_chk("reset", 1'b0, 24'h0, 1'b0, 0);
   endtask

   task automatic pix(input string nm, input int x, input int y,
                      input logic [23:0] er, input logic ea, input int ei);
      pix_valid = 1'b1;
      DrawX     = CW'(x);
      DrawY     = CW'(y);
      @(posedge Clk); #1;
      pix_valid = 1'b0;
      chk({nm, ".latency"}, 32'(rgb_valid), 32'd0);
      @(posedge Clk); #1;
      out_chk(nm, 1'b1, er, ea, ei);
   endtask

   task automatic pixm(input string nm, input int x, input int y);
      logic [23:0] r;
      logic        a;
      int          d;
      model_pix(x, y, r, a, d);
      pix(nm, x, y, r, a, d);
   endtask

   task automatic stream(input int n);
      logic [23:0] e_rgb [64];
      logic        e_v [64];
      logic        e_a [64];
      int          e_id [64];
      int          k, px, py;
      for (int c = 0; c <= n; c++) begin
         if (c < n && $urandom_range(0, 3) != 0) begin
            k  = int'($urandom_range(0, NS - 1));
            px = (m_x[k] + int'($urandom_range(0, m_sz[k] + 3))) % 1024;
            py = (m_y[k] + int'($urandom_range(0, m_sz[k] + 3))) % 1024;
            pix_valid = 1'b1;
            DrawX     = CW'(px);
            DrawY     = CW'(py);
            e_v[c]    = 1'b1;
            model_pix(px, py, e_rgb[c], e_a[c], e_id[c]);
         end else begin
            pix_valid = 1'b0;
            e_v[c]    = 1'b0;
            e_rgb[c]  = '0;
            e_a[c]    = 1'b0;
            e_id[c]   = 0;
         end
         @(posedge Clk); #1;
         if (c > 0)
            out_chk("stream", e_v[c-1], e_rgb[c-1], e_a[c-1], e_id[c-1]);
      end
      pix_valid = 1'b0;
   endtask

   initial begin
      logic [NS-1:0] msk;
      for (int i = 0; i < NS; i++) set_spr(i, 0, 0, 0, 24'h0, 1'b0);
      @(posedge Clk); #1;
      do_reset();

      set_spr(0, 100, 100, 20, CA, 1'b1);
      set_spr(1, 300, 300, 10, CB, 1'b0);
      set_spr(2, 40, 40, 30, CC, 1'b1);
      set_spr(3, 500, 300, 50, CD, 1'b1);
      pix("before_first_frame", 110, 110, 24'h000072, 1'b0, 0);
      frame('0);

      tbl[0] = '{110, 110, CA, 1'b1, 0};
      tbl[1] = '{119, 119, CA, 1'b1, 0};
      tbl[2] = '{120, 110, 24'h000070, 1'b0, 0};
      tbl[3] = '{50, 50, CC, 1'b1, 2};
      tbl[4] = '{80, 10, 24'h000075, 1'b0, 0};
      tbl[5] = '{99, 10, 24'h000073, 1'b0, 0};
      tbl[6] = '{549, 349, CD, 1'b1, 3};
      tbl[7] = '{550, 300, 24'h00003B, 1'b0, 0};
      for (int v = 0; v < 8; v++)
         pix($sformatf("vec%0d", v), tbl[v].x, tbl[v].y,
             tbl[v].rgb, tbl[v].any, tbl[v].id);
      @(posedge Clk); #1;
      out_chk("idle", 1'b0, 24'h0, 1'b0, 0);

      set_spr(0, 45, 45, 10, CA, 1'b1);
      frame('0);
      pix("overlap_low_wins", 50, 50, CA, 1'b1, 0);
      set_spr(0, 45, 45, 10, CA, 1'b0);
      frame('0);
      pix("overlap_ch0_off", 50, 50, CC, 1'b1, 2);

      set_spr(0, 100, 100, 20, CA, 1'b1);
      frame('0);
      pix("shadow_pre", 110, 110, CA, 1'b1, 0);
      set_spr(0, 300, 100, 20, CA, 1'b1);
      pix("shadow_midframe", 110, 110, CA, 1'b1, 0);
      frame('0);
      pix("shadow_after", 110, 110, 24'h000072, 1'b0, 0);

      set_spr(0, 5, 0, 20, CA, 1'b1);
      set_spr(3, 0, 0, 0, CD, 1'b1);
      frame('0);
      pix("wrap_left", 3, 5, 24'h00007F, 1'b0, 0);
      pix("wrap_inside", 6, 5, CA, 1'b1, 0);
      pix("size_zero", 0, 700, 24'h00007F, 1'b0, 0);

      set_spr(1, 200, 200, 10, CB, 1'b1);
      frame('0);
      pix("flash_pre", 205, 205, CB, 1'b1, 1);
      slice(4'b0010);
      pix("flash_on", 205, 205, WH, 1'b1, 1);
      for (int k = 1; k <= FF; k++) begin
         frame('0);
         pix($sformatf("flash_f%0d", k), 205, 205,
             (k < FF) ? WH : CB, 1'b1, 1);
      end
      slice(4'b0010);
      frame('0);
      frame('0);
      frame(4'b0010);
      pix("retrig_coincident", 205, 205, WH, 1'b1, 1);
      for (int k = 1; k <= FF; k++) begin
         frame('0);
         pix($sformatf("retrig_f%0d", k), 205, 205,
             (k < FF) ? WH : CB, 1'b1, 1);
      end

      set_spr(1, 200, 200, 10, CB, 1'b0);
      frame('0);
      slice(4'b0010);
      frame('0);
      frame('0);
      frame('0);
      set_spr(1, 200, 200, 10, CB, 1'b1);
      frame('0);
      pix("flash_while_disabled", 205, 205, WH, 1'b1, 1);

      pix_valid = 1'b1;
      DrawX     = CW'(205);
      DrawY     = CW'(205);
      @(posedge Clk); #1;
      do_reset();
      for (int k = 0; k < 3; k++) begin
         @(posedge Clk); #1;
         out_chk($sformatf("flight_drop%0d", k), 1'b0, 24'h0, 1'b0, 0);
      end
      pix("post_reset_no_sprite", 205, 205, 24'h000066, 1'b0, 0);
      frame('0);
      pix("post_reset_frame", 205, 205, CB, 1'b1, 1);

      for (int r = 0; r < 40; r++) begin
         for (int i = 0; i < NS; i++)
            set_spr(i, int'($urandom_range(0, 1023)),
                    int'($urandom_range(0, 1023)),
                    int'($urandom_range(0, 200)), 24'($urandom),
                    $urandom_range(0, 3) != 0);
         msk = ($urandom_range(0, 3) == 0) ? NS'($urandom) : '0;
         frame(msk);
         if ($urandom_range(0, 3) == 0) slice(NS'($urandom));
         pixm($sformatf("rand_single%0d", r),
              int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
         stream(30);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
